// File: rtl/corr_win_sched_if.sv
// Link-controller / correlator signal bundle for corr_win_sched.
// The scheduler uses the slave modport; its environment drives the master side.
interface corr_win_sched_if #(
  parameter int CNT_W = 10
);
  logic             p_1us;
  logic             tslot_p;
  logic [2:0]       req;
  logic [63:0]      cac_sync;
  logic [63:0]      dac_sync;
  logic [63:0]      iac_sync;
  logic [CNT_W-1:0] regi_win_open;
  logic [CNT_W-1:0] regi_win_len;
  logic             corre_trgp;
  logic             correWindow;
  logic [63:0]      ref_sync;
  logic [2:0]       grant;
  logic             busy;
  logic             win_hit_p;
  logic             win_miss_p;

  modport master (
    output p_1us, tslot_p, req, cac_sync, dac_sync, iac_sync,
           regi_win_open, regi_win_len, corre_trgp,
    input  correWindow, ref_sync, grant, busy, win_hit_p, win_miss_p
  );

  modport slave (
    input  p_1us, tslot_p, req, cac_sync, dac_sync, iac_sync,
           regi_win_open, regi_win_len, corre_trgp,
    output correWindow, ref_sync, grant, busy, win_hit_p, win_miss_p
  );
endinterface

// File: rtl/corr_win_sched.sv
// Shares the sync-word correlator between CAC/DAC/IAC: grants one requester per slot,
// opens a timed correlation window and reports hit/miss. Define CORR_RR_EN for DAC/IAC round-robin.
module corr_win_sched #(
  parameter int CNT_W = 10
) (
  input  logic             clk_6M,
  input  logic             rstz,
  corr_win_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OPEN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] dly_cnt;
  logic [CNT_W-1:0] len_cnt;
  logic [CNT_W-1:0] win_len_eff;
  logic             len_done;
  logic             abort;
  logic [2:0]       sel_grant;
  logic [63:0]      sel_sync;
`ifdef CORR_RR_EN
  logic             rr_prefer_iac;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_grant = 3'b000;
    if (bus.req[0]) begin
      sel_grant = 3'b001;
    end else if (bus.req[1] && bus.req[2]) begin
`ifdef CORR_RR_EN
      sel_grant = rr_prefer_iac ? 3'b100 : 3'b010;
`else
      sel_grant = 3'b010;
`endif
    end else if (bus.req[1]) begin
      sel_grant = 3'b010;
    end else if (bus.req[2]) begin
      sel_grant = 3'b100;
    end
  end

  always_comb begin
    sel_sync = '0;
    unique case (sel_grant)
      3'b001:  sel_sync = bus.cac_sync;
      3'b010:  sel_sync = bus.dac_sync;
      3'b100:  sel_sync = bus.iac_sync;
      default: sel_sync = '0;
    endcase
  end

  // A programmed length of 0 behaves as a 1 us window; compare one bit wider to avoid wrap.
  assign win_len_eff = (bus.regi_win_len == '0) ? CNT_ONE : bus.regi_win_len;
  assign len_done    = ({1'b0, len_cnt} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, win_len_eff};
  assign abort       = ~|(bus.req & bus.grant);
  assign bus.busy    = (state != S_IDLE);

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state           <= S_IDLE;
      dly_cnt         <= '0;
      len_cnt         <= '0;
      bus.correWindow <= 1'b0;
      bus.ref_sync    <= '0;
      bus.grant       <= '0;
      bus.win_hit_p   <= 1'b0;
      bus.win_miss_p  <= 1'b0;
`ifdef CORR_RR_EN
      rr_prefer_iac   <= 1'b0;
`endif
    end else begin
      bus.win_hit_p  <= 1'b0;
      bus.win_miss_p <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.tslot_p && |bus.req) begin
            bus.grant    <= sel_grant;
            bus.ref_sync <= sel_sync;
            dly_cnt      <= '0;
            state        <= S_WAIT;
`ifdef CORR_RR_EN
            if (sel_grant[1])      rr_prefer_iac <= 1'b1;
            else if (sel_grant[2]) rr_prefer_iac <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          if (abort) begin
            bus.correWindow <= 1'b0;
            bus.grant       <= '0;
            bus.ref_sync    <= '0;
            state           <= S_IDLE;
          end else if (bus.p_1us) begin
            if (dly_cnt == bus.regi_win_open) begin
              bus.correWindow <= 1'b1;
              len_cnt         <= '0;
              state           <= S_OPEN;
            end else begin
              dly_cnt <= sat_inc(dly_cnt);
            end
          end
        end
        S_OPEN: begin
          // Abort beats hit/miss; hit beats a coincident expiry.
          if (abort) begin
            bus.correWindow <= 1'b0;
            bus.grant       <= '0;
            bus.ref_sync    <= '0;
            state           <= S_IDLE;
          end else if (bus.p_1us) begin
            if (bus.corre_trgp || len_done) begin
              bus.correWindow <= 1'b0;
              bus.grant       <= '0;
              bus.ref_sync    <= '0;
              bus.win_hit_p   <= bus.corre_trgp;
              bus.win_miss_p  <= ~bus.corre_trgp;
              state           <= S_IDLE;
            end else begin
              len_cnt <= sat_inc(len_cnt);
            end
          end
        end
        default: begin
          bus.correWindow <= 1'b0;
          bus.grant       <= '0;
          bus.ref_sync    <= '0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corr_win_sched.sv
// Self-checking bench for corr_win_sched: directed slots plus randomized slots,
// each compared µs by µs against a timeline model derived from the scheduling rules.
`timescale 1ns/1ps
module tb_corr_win_sched;
  localparam int CNT_W = 10;

  logic clk_6M = 1'b0;
  logic rstz;
  int   n_cmp = 0;
  int   n_mis = 0;
`ifdef CORR_RR_EN
  logic prefer_iac;
`endif

  corr_win_sched_if #(.CNT_W(CNT_W)) bus ();
  corr_win_sched #(.CNT_W(CNT_W)) dut (.clk_6M(clk_6M), .rstz(rstz), .bus(bus));

  always #83 clk_6M = ~clk_6M;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk_6M);
      #1;
    end
  endtask

  // One p_1us strobe (optionally slot boundary / trigger), sampled 1 ns after the edge.
  task automatic pulse_us(input logic tslot, input logic trg);
    bus.p_1us      = 1'b1;
    bus.tslot_p    = tslot;
    bus.corre_trgp = trg;
    @(posedge clk_6M);
    #1;
    bus.p_1us      = 1'b0;
    bus.tslot_p    = 1'b0;
    bus.corre_trgp = 1'b0;
  endtask

  function automatic logic [2:0] model_grant(input logic [2:0] r);
    if (r[0]) return 3'b001;
    if (r[1] && r[2]) begin
`ifdef CORR_RR_EN
      return prefer_iac ? 3'b100 : 3'b010;
`else
      return 3'b010;
`endif
    end
    if (r[1]) return 3'b010;
    if (r[2]) return 3'b100;
    return 3'b000;
  endfunction

  task automatic new_words();
    bus.cac_sync = {$urandom, $urandom};
    bus.dac_sync = {$urandom, $urandom};
    bus.iac_sync = {$urandom, $urandom};
  endtask

  // Slot model: tslot at µs 0, window high for µs open+1 .. close-1, result pulse after µs close.
  // trig_t = n triggers on the n-th window µs; 0 means no trigger.
  task automatic run_slot(input string tag, input logic [2:0] r, input int open_v,
                          input int len_v, input int trig_t, input bit noise);
    logic [2:0]  g;
    logic [63:0] rs;
    int          wmax, dur, close_k;
    bit          hit, active;
    new_words();
    bus.req           = r;
    bus.regi_win_open = CNT_W'(open_v);
    bus.regi_win_len  = CNT_W'(len_v);
    g  = model_grant(r);
    rs = (g == 3'b001) ? bus.cac_sync : (g == 3'b010) ? bus.dac_sync :
         (g == 3'b100) ? bus.iac_sync : 64'd0;
`ifdef CORR_RR_EN
    if (g == 3'b010)      prefer_iac = 1'b1;
    else if (g == 3'b100) prefer_iac = 1'b0;
`endif
    active  = (r != 3'b000);
    wmax    = (len_v == 0) ? 1 : len_v;
    hit     = active && trig_t != 0 && trig_t <= wmax;
    dur     = hit ? trig_t : wmax;
    close_k = active ? open_v + 1 + dur : 0;
    for (int k = 0; k <= close_k + 1; k++) begin
      logic trg;
      bit   in_win, busy_e, res_k;
      trg = (trig_t != 0 && k == open_v + 1 + trig_t);
      if (noise && k >= 1 && k <= open_v) trg = 1'($urandom_range(0, 1));
      if (noise && k >= 1) bus.req = r | 3'($urandom_range(0, 7));
      pulse_us(k == 0, trg);
      busy_e = active && k < close_k;
      in_win = active && k >= open_v + 1 && k < close_k;
      res_k  = active && k == close_k;
      check($sformatf("%s k=%0d win", tag, k),   bus.correWindow, in_win);
      check($sformatf("%s k=%0d busy", tag, k),  bus.busy, busy_e);
      check($sformatf("%s k=%0d grant", tag, k), bus.grant, busy_e ? g : 3'b000);
      check($sformatf("%s k=%0d ref", tag, k),   bus.ref_sync, busy_e ? rs : 64'd0);
      check($sformatf("%s k=%0d hit", tag, k),   bus.win_hit_p, res_k && hit);
      check($sformatf("%s k=%0d miss", tag, k),  bus.win_miss_p, res_k && !hit);
      idle_cycles(1);
      if (res_k) begin
        check($sformatf("%s hit_width", tag),  bus.win_hit_p, 1'b0);
        check($sformatf("%s miss_width", tag), bus.win_miss_p, 1'b0);
      end
      idle_cycles(4);
    end
  endtask

  initial begin
    int pulses;
    rstz              = 1'b0;
    bus.p_1us         = 1'b0;
    bus.tslot_p       = 1'b0;
    bus.req           = 3'b000;
    bus.corre_trgp    = 1'b0;
    bus.regi_win_open = '0;
    bus.regi_win_len  = '0;
    new_words();
`ifdef CORR_RR_EN
    prefer_iac = 1'b0;
`endif
    idle_cycles(3);
    check("rst win",   bus.correWindow, 1'b0);
    check("rst ref",   bus.ref_sync, 64'd0);
    check("rst grant", bus.grant, 3'b000);
    check("rst busy",  bus.busy, 1'b0);
    check("rst hit",   bus.win_hit_p, 1'b0);
    check("rst miss",  bus.win_miss_p, 1'b0);
    #20 rstz = 1'b1;
    idle_cycles(2);

    // Directed slots
    run_slot("cac_miss",  3'b001, 5, 10, 0, 1'b0);
    run_slot("cac_hit4",  3'b001, 5, 10, 4, 1'b0);
    run_slot("cac_hit10", 3'b001, 5, 10, 10, 1'b0);
    run_slot("noreq",     3'b000, 3, 3, 0, 1'b0);
    run_slot("arb0",      3'b110, 2, 4, 1, 1'b0);
    run_slot("arb1",      3'b110, 2, 4, 1, 1'b0);
    run_slot("arb2",      3'b110, 2, 4, 1, 1'b0);
    run_slot("cac_over",  3'b111, 1, 2, 0, 1'b0);
    run_slot("zero_win",  3'b001, 0, 0, 0, 1'b0);

    // Abort: drop the granted IAC request while the window is open
    new_words();
    bus.req           = 3'b100;
    bus.regi_win_open = CNT_W'(2);
    bus.regi_win_len  = CNT_W'(6);
`ifdef CORR_RR_EN
    prefer_iac = 1'b0;
`endif
    pulse_us(1'b1, 1'b0);
    idle_cycles(5);
    for (int k = 1; k <= 4; k++) begin
      pulse_us(1'b0, 1'b0);
      idle_cycles(5);
    end
    check("abort pre win",   bus.correWindow, 1'b1);
    check("abort pre grant", bus.grant, 3'b100);
    check("abort pre ref",   bus.ref_sync, bus.iac_sync);
    bus.req = 3'b000;
    idle_cycles(1);
    check("abort win",   bus.correWindow, 1'b0);
    check("abort busy",  bus.busy, 1'b0);
    check("abort grant", bus.grant, 3'b000);
    check("abort ref",   bus.ref_sync, 64'd0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      pulse_us(1'b0, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 6; c++) begin
        pulses += int'(bus.win_hit_p) + int'(bus.win_miss_p);
        idle_cycles(1);
      end
    end
    check("abort no pulse", 64'(pulses), 64'd0);
    check("abort idle",     bus.busy, 1'b0);

    // Randomized slots
    for (int n = 0; n < 24; n++) begin
      int o, l, w;
      o = $urandom_range(0, 8);
      l = $urandom_range(0, 8);
      w = (l == 0) ? 1 : l;
      run_slot($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), o, l,
               $urandom_range(0, w + 2), 1'b1);
    end

    // Zero-length window at offset 0, then asynchronous reset mid-window
    new_words();
    bus.req           = 3'b001;
    bus.regi_win_open = '0;
    bus.regi_win_len  = '0;
    pulse_us(1'b1, 1'b0);
    idle_cycles(5);
    pulse_us(1'b0, 1'b0);
    check("mid win open",  bus.correWindow, 1'b1);
    check("mid win grant", bus.grant, 3'b001);
    idle_cycles(2);
    #20 rstz = 1'b0;
    #1;
    check("arst win",   bus.correWindow, 1'b0);
    check("arst ref",   bus.ref_sync, 64'd0);
    check("arst grant", bus.grant, 3'b000);
    check("arst busy",  bus.busy, 1'b0);
    check("arst hit",   bus.win_hit_p, 1'b0);
    check("arst miss",  bus.win_miss_p, 1'b0);
    idle_cycles(2);
    #20 rstz = 1'b1;
`ifdef CORR_RR_EN
    prefer_iac = 1'b0;
`endif
    idle_cycles(2);
    run_slot("post_rst", 3'b110, 0, 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
